div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
//  Sequencer for the iterative restoring divider built around the 64-bit Remainder register and the 32-bit ALU.
//  - Accepts one divide request through a start/ready handshake and latches the operands.
//  - Drives the Remainder write control and the ALU subtract for WIDTH iterations.
//  - Captures quotient/remainder into held output registers and pulses done.
// PARAMETERS
//  WIDTH  32                    operand width; Remainder register is 2*WIDTH bits
//  CNT_W  $clog2(WIDTH+1)       iteration counter width (derived, do not override)
// PORTS
//  clk          in   1        clock, all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  start        in   1        request; accepted only on a clk edge where start && ready
//  dividend     in   WIDTH    dividend, sampled on accept
//  divisor      in   WIDTH    divisor, sampled on accept
//  rem_in       in   2*WIDTH  Remainder register output (Remainder_out)
//  rem_w_ctrl   out  1        to Remainder W_ctrl; 0=load {0,dividend,0}, 1=iterate
//  dividend_out out  WIDTH    latched dividend, to Remainder Dividend_in
//  divisor_out  out  WIDTH    latched divisor, to ALU B (ALU A = rem_in[2W-1:W])
//  alu_sub      out  1        1 = ALU performs A-B (ALU carry=1 means negative)
//  ready        out  1        idle, can accept start
//  done         out  1        one-cycle pulse: quotient/remainder valid
//  quotient     out  WIDTH    held result until next done
//  remainder    out  WIDTH    held result until next done
//  div_zero     out  1        held flag, see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=IDLE, ready=1, done=0, rem_w_ctrl=0, alu_sub=0, cnt=0, quotient=remainder=0, div_zero=0, operand latches=0.
//  - States: IDLE -> LOAD -> RUN -> CAPT -> IDLE.
//    IDLE: ready=1, rem_w_ctrl=0 (Remainder reloads latched dividend each cycle, harmless); on start: latch operands, -> LOAD.
//    LOAD: one cycle, rem_w_ctrl=0, ready=0; Remainder loads {0,dividend,0}; cnt<=0; -> RUN.
//    RUN: rem_w_ctrl=1, alu_sub=1; cnt increments per edge; exactly WIDTH cycles; on cnt==WIDTH-1 -> CAPT.
//    CAPT: rem_w_ctrl=0 (Remainder has no hold; its next reload is harmless because capture uses the current value);
//          quotient<=rem_in[W-1:0], remainder<={1'b0,rem_in[2W-1:W+1]}; done<=1; -> IDLE.
//  - Timing (E0 = edge sampling start): LOAD after E0, Remainder loaded at E1, WIDTH updates at E2..E(W+1), capture at E(W+2).
//    With W=32: done=1 and outputs valid in the cycle after E34; ready=0 from E0 through E34.
//  - done: high exactly one cycle, coincident with ready returning to 1; quotient/remainder/div_zero stable until the next done.
//  - Back-to-back: start high in the done cycle is accepted (ready=1); outputs still hold the previous result until the new done.
//  - start while ready=0: ignored, no queuing; dividend/divisor changes while busy have no effect.
//  - rst mid-operation: synchronous abort; next cycle is IDLE with reset values; no done for the aborted request.
//  - rst and start on the same edge: rst wins, request dropped.
//  - No overflow case for unsigned divide; all arithmetic unsigned, widths exact, no truncation beyond stated slices.
// CONFIGURATION
//  DIV_ZERO_DETECT_EN defined:
//    - Accept with divisor==0 skips LOAD/RUN; at E1: quotient={WIDTH{1'b1}}, remainder=dividend, div_zero=1, done=1, ready=1.
//    - Any normal completion clears div_zero to 0.
//  DIV_ZERO_DETECT_EN undefined:
//    - div_zero tied 0; divisor==0 runs the full sequence.
//    - Result is datapath-defined: quotient={WIDTH{1'b1}}, remainder={1'b0,dividend[W-2:0]}.
// TESTING (bench instantiates div_seq_ctrl + Remainder + behavioural ALU, WIDTH=32)
//  - 100/7 -> quotient=14, remainder=2, done exactly 34 edges after the start edge; ready=0 for the whole interval.
//  - 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0; 5/9 -> quotient=0, remainder=5.
//  - start pulsed at cycle 10 of a 1000/3 run with 7/2 -> ignored; 1000/3 yields 333 rem 1, single done pulse.
//  - rst asserted at RUN cycle 10 of 100/7 -> next cycle ready=1, rem_w_ctrl=0, quotient=0; no done within 40 cycles.
//  - Back-to-back: start held through done of 100/7, second op 81/9 -> second done 34 edges later, quotient=9, remainder=0.
//  - 42/0 with DIV_ZERO_DETECT_EN -> done at E1, quotient=0xFFFFFFFF, remainder=42, div_zero=1.
//    Without the macro -> done at E34, quotient=0xFFFFFFFF, remainder=42, div_zero=0.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: control sequencer for an iterative restoring divider.
// Latches one request, runs the external Remainder register and ALU for
// WIDTH subtract/shift iterations, then captures quotient and remainder
// into held output registers and pulses done for one cycle.
//
// Optional build macro: DIV_ZERO_DETECT_EN
//   defined   -> a zero divisor bypasses the iterations and completes one
//                edge after accept with quotient all-ones, remainder equal
//                to the dividend and div_zero set.
//   undefined -> div_zero is tied low and a zero divisor runs the full
//                sequence; the result is whatever the datapath produces.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready high, Remainder reloads the latched dividend harmlessly
// LOAD  | one cycle, Remainder loads {0, dividend, 0}
// RUN   | WIDTH cycles of subtract/shift, cnt counts 0..WIDTH-1
// CAPT  | final Remainder value captured, done pulsed, back to IDLE
// ZERO  | divide-by-zero shortcut, only reachable with detection enabled

module div_seq_ctrl #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [2*WIDTH-1:0]   rem_in,
    output logic                 rem_w_ctrl,
    output logic [WIDTH-1:0]     dividend_out,
    output logic [WIDTH-1:0]     divisor_out,
    output logic                 alu_sub,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        ZERO = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Upper half of the Remainder register. The final remainder sits one
    // bit to the left (the algorithm shifts once too often), so it is
    // shifted right by one on capture.
    logic [WIDTH-1:0] rem_hi;
    assign rem_hi = rem_in[2*WIDTH-1:WIDTH];

`ifdef DIV_ZERO_DETECT_EN
    logic div_zero_q;
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    // Sequencer: state, iteration counter, operand latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ready        <= 1'b1;
            done         <= 1'b0;
            rem_w_ctrl   <= 1'b0;
            alu_sub      <= 1'b0;
            dividend_out <= '0;
            divisor_out  <= '0;
            quotient     <= '0;
            remainder    <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    rem_w_ctrl <= 1'b0;
                    alu_sub    <= 1'b0;
                    if (start && ready) begin
                        dividend_out <= dividend;
                        divisor_out  <= divisor;
                        ready        <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            state <= ZERO;
                        end else begin
                            state <= LOAD;
                        end
`else
                        state <= LOAD;
`endif
                    end
                end
                LOAD: begin
                    cnt        <= '0;
                    rem_w_ctrl <= 1'b1;
                    alu_sub    <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        rem_w_ctrl <= 1'b0;
                        alu_sub    <= 1'b0;
                        state      <= CAPT;
                    end
                end
                CAPT: begin
                    quotient  <= rem_in[WIDTH-1:0];
                    remainder <= rem_hi >> 1;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero_q <= 1'b0;
`endif
                    done      <= 1'b1;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
`ifdef DIV_ZERO_DETECT_EN
                ZERO: begin
                    quotient   <= '1;
                    remainder  <= dividend_out;
                    div_zero_q <= 1'b1;
                    done       <= 1'b1;
                    ready      <= 1'b1;
                    state      <= IDLE;
                end
`endif
                default: begin
                    rem_w_ctrl <= 1'b0;
                    alu_sub    <= 1'b0;
                    ready      <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
